// File: rtl/ifu_pkg.sv
// Shared widths, fetch-entry layout and alignment mask
// for the instruction fetch unit.
package ifu_pkg;
   localparam int DW    = 64;
   localparam int IW    = 32;
   localparam int MW    = 64;
   localparam int DEPTH = 2;

   localparam logic [DW-1:0] ALIGN_MASK = {{(DW-3){1'b1}}, 3'b000};

   typedef struct packed {
      logic [IW-1:0] inst;
      logic [DW-1:0] pc;
      logic          misalign;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus: PC stream in, memory request/response,
// instruction stream out. master = fetch unit side.
interface ifu_fetch_if;
   import ifu_pkg::*;

   logic          fa_valid;
   logic          fa_ready;
   logic [DW-1:0] fa_pc;
   logic          flush;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [DW-1:0] imem_req_addr;
   logic          imem_rsp_valid;
   logic [MW-1:0] imem_rsp_data;
   logic          inst_valid;
   logic          inst_ready;
   logic [IW-1:0] inst;
   logic [DW-1:0] inst_pc;
   logic          inst_misalign;

   modport master (
      input  fa_valid, fa_pc, flush,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  inst_ready,
      output fa_ready, imem_req_valid, imem_req_addr,
      output inst_valid, inst, inst_pc, inst_misalign
   );

   modport slave (
      output fa_valid, fa_pc, flush,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output inst_ready,
      input  fa_ready, imem_req_valid, imem_req_addr,
      input  inst_valid, inst, inst_pc, inst_misalign
   );
endinterface

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with synchronous clear.
// Push while full is only honoured together with a pop.
module ifu_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push)
                        - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: credit-limited in-order reads,
// PC-tagged instruction buffer, wrong-path drop on flush.
module ifu_fetch #(
   parameter int DEPTH = ifu_pkg::DEPTH
) (
   input logic         clk,
   input logic         rst,
   ifu_fetch_if.master bus
);
   import ifu_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0] inflight_q;
   logic [CW-1:0] drop_q;
   logic [CW-1:0] out_count;
   logic [CW-1:0] pcq_count;
   logic          pcq_full;
   logic          pcq_empty;
   logic          out_full;
   logic          out_empty;
   logic [DW-1:0] rsp_pc;
   fetch_entry_t  out_din;
   fetch_entry_t  out_dout;
   fetch_entry_t  hold_q;
   fetch_entry_t  cur;
   logic          has_credit;
   logic          req_ok;
   logic          fa_fire;
   logic          rsp;
   logic          out_push;
   logic          out_pop;
   logic          unused_ok;

   // credits come from registered state only
   assign has_credit = ({1'b0, inflight_q} + {1'b0, out_count})
                       < (CW+1)'(DEPTH);
   assign req_ok     = has_credit & ~bus.flush & ~rst;

   assign bus.imem_req_valid = bus.fa_valid & req_ok;
   assign bus.fa_ready       = bus.imem_req_ready & req_ok;
   assign bus.imem_req_addr  = bus.fa_pc & ALIGN_MASK;

   assign fa_fire  = bus.fa_valid & bus.fa_ready;
   assign rsp      = bus.imem_rsp_valid;
   assign out_push = rsp & (drop_q == '0) & ~bus.flush;
   assign out_pop  = bus.inst_valid & bus.inst_ready;

   always_comb begin
      out_din          = '0;
      out_din.inst     = rsp_pc[2] ? bus.imem_rsp_data[63:32]
                                   : bus.imem_rsp_data[31:0];
      out_din.pc       = rsp_pc;
      out_din.misalign = |rsp_pc[1:0];
   end

   ifu_fifo #(.W(DW), .DEPTH(DEPTH)) u_pcq (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .push  (fa_fire),
      .din   (bus.fa_pc),
      .pop   (rsp),
      .dout  (rsp_pc),
      .full  (pcq_full),
      .empty (pcq_empty),
      .count (pcq_count)
   );

   ifu_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_outq (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.flush),
      .push  (out_push),
      .din   (out_din),
      .pop   (out_pop),
      .dout  (out_dout),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= '0;
         drop_q     <= '0;
         hold_q     <= '0;
      end else begin
         inflight_q <= inflight_q + CW'(fa_fire) - CW'(rsp);
         // everything still outstanding after the flush is wrong-path
         if (bus.flush)
            drop_q <= inflight_q - CW'(rsp);
         else if (rsp && drop_q != '0)
            drop_q <= drop_q - CW'(1);
         if (out_pop) hold_q <= out_dout;
      end
   end

   assign cur               = out_empty ? hold_q : out_dout;
   assign bus.inst_valid    = ~out_empty;
   assign bus.inst          = cur.inst;
   assign bus.inst_pc       = cur.pc;
   assign bus.inst_misalign = cur.misalign;

   assign unused_ok = ^{pcq_full, pcq_empty, pcq_count, out_full};

   a_rsp_inflight: assert property (
      @(posedge clk) disable iff (rst)
      rsp |-> (inflight_q != '0));

   a_inst_stable: assert property (
      @(posedge clk) disable iff (rst)
      (bus.inst_valid && !bus.inst_ready && !bus.flush)
      |=> ($stable(bus.inst) && $stable(bus.inst_pc)));
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: vector table plus
// stall, flush and reset sequences against a memory model.
module tb_ifu_fetch;
   import ifu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ifu_fetch_if bus();

   ifu_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   int          lat = 1;
   logic        fixed_en = 1'b1;
   logic [63:0] fixed_data = 64'h00000013_00100093;
   int          cyc = 0;
   int          req_cnt = 0;

   typedef struct {
      logic [63:0] addr;
      int          due;
   } mreq_t;
   mreq_t mq[$];

   typedef struct {
      logic [63:0] pc;
      logic [63:0] addr;
      logic [31:0] inst;
      logic        mis;
   } vec_t;
   vec_t vecs[6];

   function automatic logic [63:0] mdata(input logic [63:0] a);
      logic [31:0] b;
      b = a[31:0];
      if (fixed_en) return fixed_data;
      return {b + 32'h1000_0004, b + 32'h1000_0000};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
      end else begin
         if (bus.imem_rsp_valid && mq.size() > 0)
            void'(mq.pop_front());
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            mq.push_back('{bus.imem_req_addr, cyc + lat});
            req_cnt++;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mdata(mq[0].addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  nm, act, exp);
      end
   endtask

   task automatic fetch_one(input vec_t v, input int i);
      @(negedge clk);
      bus.fa_valid   = 1'b1;
      bus.fa_pc      = v.pc;
      bus.inst_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_addr", i), bus.imem_req_addr, v.addr);
      chk($sformatf("v%0d_fa_ready", i), bus.fa_ready, 1);
      @(negedge clk);
      bus.fa_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_valid_c1", i), bus.inst_valid, 0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_valid_c2", i), bus.inst_valid, 1);
      chk($sformatf("v%0d_inst", i), bus.inst, v.inst);
      chk($sformatf("v%0d_pc", i), bus.inst_pc, v.pc);
      chk($sformatf("v%0d_mis", i), bus.inst_misalign, v.mis);
      bus.inst_ready = 1'b1;
      @(negedge clk);
      bus.inst_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_popped", i), bus.inst_valid, 0);
      chk($sformatf("v%0d_hold", i), bus.inst, v.inst);
   endtask

   // two requests, then flush in the cycle given by its offset
   task automatic flush_seq(input string nm, input int l,
                            input logic [63:0] base);
      int bad;
      lat = l;
      bus.inst_ready = 1'b1;
      @(negedge clk);
      bus.fa_valid = 1'b1;
      bus.fa_pc    = base;
      #1;
      chk({nm, "_rdy0"}, bus.fa_ready, 1);
      @(negedge clk);
      bus.fa_pc = base + 64'h4;
      #1;
      chk({nm, "_rdy1"}, bus.fa_ready, 1);
      @(negedge clk);
      bus.flush = 1'b1;
      bus.fa_pc = base + 64'h8;
      #1;
      chk({nm, "_blk_rdy"}, bus.fa_ready, 0);
      chk({nm, "_blk_req"}, bus.imem_req_valid, 0);
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.fa_valid = 1'b0;
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (bus.inst_valid) bad++;
         @(negedge clk);
      end
      chk({nm, "_no_inst"}, bad, 0);
      chk({nm, "_drop0"}, dut.drop_q, 0);
   endtask

   initial begin
      int          sent;
      int          got;
      int          r0;
      int          bad;
      logic        hs;
      logic        found;
      logic [31:0] ep;

      vecs[0] = '{64'h8000_0000, 64'h8000_0000, 32'h0010_0093, 1'b0};
      vecs[1] = '{64'h8000_0004, 64'h8000_0000, 32'h0000_0013, 1'b0};
      vecs[2] = '{64'h8000_0002, 64'h8000_0000, 32'h0010_0093, 1'b1};
      vecs[3] = '{64'h8000_0007, 64'h8000_0000, 32'h0000_0013, 1'b1};
      vecs[4] = '{64'h8000_0ffc, 64'h8000_0ff8, 32'h0000_0013, 1'b0};
      vecs[5] = '{64'h0000_0008, 64'h0000_0008, 32'h0010_0093, 1'b0};

      bus.fa_valid       = 1'b0;
      bus.fa_pc          = '0;
      bus.flush          = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.inst_ready     = 1'b0;
      #1 rst = 1'b1;
      #1;
      bus.fa_valid = 1'b1;
      bus.fa_pc    = 64'h8000_0000;
      #1;
      chk("rst_fa_ready", bus.fa_ready, 0);
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_inst_valid", bus.inst_valid, 0);
      chk("rst_inst", bus.inst, 0);
      chk("rst_inst_pc", bus.inst_pc, 0);
      chk("rst_mis", bus.inst_misalign, 0);
      repeat (2) @(negedge clk);
      rst          = 1'b0;
      bus.fa_valid = 1'b0;

      for (int i = 0; i < 6; i++) fetch_one(vecs[i], i);

      // stream with decode stalled, then released
      fixed_en = 1'b0;
      lat      = 1;
      sent     = 0;
      got      = 0;
      r0       = req_cnt;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         bus.fa_valid = 1'b1;
         bus.fa_pc    = 64'h8000_0000 + 64'(4 * sent);
         #1;
         hs = bus.fa_ready;
         @(posedge clk);
         if (hs) sent++;
      end
      @(negedge clk);
      #1;
      chk("stall_reqs", req_cnt - r0, 2);
      chk("stall_fa_ready", bus.fa_ready, 0);
      chk("stall_req_valid", bus.imem_req_valid, 0);
      for (int c = 0; c < 40 && got < 8; c++) begin
         @(negedge clk);
         bus.fa_valid   = (sent < 8);
         bus.fa_pc      = 64'h8000_0000 + 64'(4 * sent);
         bus.inst_ready = 1'b1;
         #1;
         hs = bus.fa_valid & bus.fa_ready;
         if (bus.inst_valid) begin
            ep = 32'h9000_0000 + 32'(4 * got);
            chk($sformatf("s%0d_pc", got), bus.inst_pc,
                64'h8000_0000 + 64'(4 * got));
            chk($sformatf("s%0d_inst", got), bus.inst, ep);
            got++;
         end
         @(posedge clk);
         if (hs) sent++;
      end
      chk("stream_count", got, 8);

      flush_seq("fl3", 3, 64'h8000_0100);

      // refetch after the flush
      @(negedge clk);
      bus.fa_valid = 1'b1;
      bus.fa_pc    = 64'h8000_1000;
      #1;
      chk("refetch_rdy", bus.fa_ready, 1);
      @(negedge clk);
      bus.fa_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         #1;
         if (bus.inst_valid) begin
            found = 1'b1;
            chk("refetch_pc", bus.inst_pc, 64'h8000_1000);
            chk("refetch_inst", bus.inst, 32'h9000_1000);
         end
         @(negedge clk);
      end
      chk("refetch_seen", found, 1);

      // flush in the cycle of the first response
      flush_seq("fl2", 2, 64'h8000_0200);

      lat            = 1;
      bus.inst_ready = 1'b0;
      r0             = req_cnt;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.fa_valid = 1'b1;
         bus.fa_pc    = 64'h8000_3000;
         @(posedge clk);
      end
      @(negedge clk);
      chk("credits_back", req_cnt - r0, DEPTH);
      bus.fa_valid   = 1'b0;
      bus.inst_ready = 1'b1;
      repeat (4) @(negedge clk);
      bus.inst_ready = 1'b0;
      #1;
      chk("drained", bus.inst_valid, 0);

      // reset pulse with an instruction buffered
      @(negedge clk);
      bus.fa_valid = 1'b1;
      bus.fa_pc    = 64'h8000_2000;
      @(negedge clk);
      bus.fa_pc = 64'h8000_2004;
      @(negedge clk);
      #1;
      chk("pre_rst_valid", bus.inst_valid, 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", bus.inst_valid, 0);
      chk("mid_rst_inst", bus.inst, 0);
      chk("mid_rst_pc", bus.inst_pc, 0);
      chk("mid_rst_mis", bus.inst_misalign, 0);
      chk("mid_rst_fa_ready", bus.fa_ready, 0);
      chk("mid_rst_req", bus.imem_req_valid, 0);
      @(negedge clk);
      rst          = 1'b0;
      bus.fa_valid = 1'b0;
      bad = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (bus.inst_valid) bad++;
      end
      chk("post_rst_stale", bad, 0);
      chk("post_rst_pc", bus.inst_pc, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
